// File: rtl/instr_fetch_stage_if.sv
// Interface bundling the fetch stage's control, instruction-ROM and IF/ID signals.
// The slave modport is the fetch stage; the master modport is its environment
// (hazard unit, branch resolution, instruction ROM and the ID stage).
interface instr_fetch_stage_if #(
    parameter int LEN_WORD = 32
);
    logic                stall;
    logic                redirect_valid;
    logic [LEN_WORD-1:0] redirect_pc;
    logic [LEN_WORD-1:0] imem_addr;
    logic [LEN_WORD-1:0] imem_data;
    logic [LEN_WORD-1:0] ifid_instr;
    logic [LEN_WORD-1:0] ifid_pc_plus4;
    logic                ifid_valid;
    logic                halted;

    modport slave (
        input  stall,
        input  redirect_valid,
        input  redirect_pc,
        input  imem_data,
        output imem_addr,
        output ifid_instr,
        output ifid_pc_plus4,
        output ifid_valid,
        output halted
    );

    modport master (
        output stall,
        output redirect_valid,
        output redirect_pc,
        output imem_data,
        input  imem_addr,
        input  ifid_instr,
        input  ifid_pc_plus4,
        input  ifid_valid,
        input  halted
    );
endinterface

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage of the MIPS pipeline.
// Owns the PC, presents it as the byte address to a zero-latency instruction ROM
// and captures the returned word into the IF/ID register. Redirects from later
// stages flush IF/ID and reload the PC; hazard stalls freeze PC and IF/ID.
// Fetching stops (HALT) once the PC leaves [0, SIZE_MEM*4).
// Optional build macro FETCH_PERF_CNT_EN adds saturating fetch/stall/flush counters.
module instr_fetch_stage #(
    parameter int LEN_WORD = 32,
    parameter int RESET_PC = 0,
    parameter int SIZE_MEM = 256
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    instr_fetch_stage_if.slave     bus
`ifdef FETCH_PERF_CNT_EN
   ,output logic [LEN_WORD-1:0]    o_fetch_count,
    output logic [LEN_WORD-1:0]    o_stall_count,
    output logic [LEN_WORD-1:0]    o_flush_count
`endif
);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    localparam logic [LEN_WORD-1:0] C_LIMIT      = LEN_WORD'(SIZE_MEM * 4);
    localparam logic [LEN_WORD-1:0] C_RESET_PC   = LEN_WORD'(RESET_PC);
    localparam logic [LEN_WORD-1:0] C_STEP       = LEN_WORD'(4);
    localparam logic [LEN_WORD-1:0] C_ALIGN_MASK = ~(LEN_WORD'(3));
    localparam logic [LEN_WORD-1:0] C_ZERO       = '0;

    state_t              r_state;
    logic [LEN_WORD-1:0] r_pc;
    logic [LEN_WORD-1:0] r_ifid_instr;
    logic [LEN_WORD-1:0] r_ifid_pc_plus4;
    logic                r_ifid_valid;

    logic [LEN_WORD-1:0] w_pc_plus4;
    logic [LEN_WORD-1:0] w_redirect_target;

    // Sequential PC increment wraps naturally modulo 2^LEN_WORD; targets are word aligned.
    assign w_pc_plus4        = r_pc + C_STEP;
    assign w_redirect_target = bus.redirect_pc & C_ALIGN_MASK;

    assign bus.imem_addr     = r_pc;
    assign bus.ifid_instr    = r_ifid_instr;
    assign bus.ifid_pc_plus4 = r_ifid_pc_plus4;
    assign bus.ifid_valid    = r_ifid_valid;
    assign bus.halted        = (r_state == ST_HALT);

    // PC, IF/ID register and RUN/HALT state; priority reset > redirect > stall > advance.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= ST_RUN;
            r_pc            <= C_RESET_PC;
            r_ifid_instr    <= C_ZERO;
            r_ifid_pc_plus4 <= C_ZERO;
            r_ifid_valid    <= 1'b0;
        end else if (bus.redirect_valid) begin
            // Redirect wins even in HALT or under stall; IF/ID becomes a bubble.
            r_pc            <= w_redirect_target;
            r_ifid_instr    <= C_ZERO;
            r_ifid_pc_plus4 <= C_ZERO;
            r_ifid_valid    <= 1'b0;
            r_state         <= (w_redirect_target < C_LIMIT) ? ST_RUN : ST_HALT;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (bus.stall) begin
                        r_pc            <= r_pc;
                        r_ifid_instr    <= r_ifid_instr;
                        r_ifid_pc_plus4 <= r_ifid_pc_plus4;
                        r_ifid_valid    <= r_ifid_valid;
                        r_state         <= ST_RUN;
                    end else begin
                        // The last in-range word is still captured on the edge that halts.
                        r_pc            <= w_pc_plus4;
                        r_ifid_instr    <= bus.imem_data;
                        r_ifid_pc_plus4 <= w_pc_plus4;
                        r_ifid_valid    <= 1'b1;
                        r_state         <= (w_pc_plus4 < C_LIMIT) ? ST_RUN : ST_HALT;
                    end
                end
                ST_HALT: begin
                    r_pc            <= r_pc;
                    r_ifid_instr    <= C_ZERO;
                    r_ifid_pc_plus4 <= C_ZERO;
                    r_ifid_valid    <= 1'b0;
                    r_state         <= ST_HALT;
                end
                default: begin
                    r_pc            <= r_pc;
                    r_ifid_instr    <= C_ZERO;
                    r_ifid_pc_plus4 <= C_ZERO;
                    r_ifid_valid    <= 1'b0;
                    r_state         <= ST_HALT;
                end
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [LEN_WORD-1:0] r_fetch_count;
    logic [LEN_WORD-1:0] r_stall_count;
    logic [LEN_WORD-1:0] r_flush_count;
    logic                w_advance;
    logic                w_stall_hold;
    logic                w_flush;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [LEN_WORD-1:0] sat_inc(input logic [LEN_WORD-1:0] value);
        logic [LEN_WORD-1:0] result;
        if (&value) begin
            result = value;
        end else begin
            result = value + LEN_WORD'(1);
        end
        return result;
    endfunction

    // Decode which kind of edge is about to happen, mirroring the PC priority order.
    always_comb begin
        w_advance    = 1'b0;
        w_stall_hold = 1'b0;
        w_flush      = 1'b0;
        if (i_reset) begin
            w_flush = 1'b0;
        end else if (bus.redirect_valid) begin
            w_flush = 1'b1;
        end else if (r_state == ST_RUN) begin
            w_stall_hold = bus.stall;
            w_advance    = ~bus.stall;
        end else begin
            w_advance = 1'b0;
        end
    end

    // Saturating event counters, cleared by reset.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_fetch_count <= C_ZERO;
            r_stall_count <= C_ZERO;
            r_flush_count <= C_ZERO;
        end else begin
            r_fetch_count <= w_advance    ? sat_inc(r_fetch_count) : r_fetch_count;
            r_stall_count <= w_stall_hold ? sat_inc(r_stall_count) : r_stall_count;
            r_flush_count <= w_flush      ? sat_inc(r_flush_count) : r_flush_count;
        end
    end

    assign o_fetch_count = r_fetch_count;
    assign o_stall_count = r_stall_count;
    assign o_flush_count = r_flush_count;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Self-checking bench for instr_fetch_stage: directed table, hand-written
// boundary sequences and randomized cycles against a behavioural model.
module tb_instr_fetch_stage;

    localparam logic [31:0] LIMIT = 32'h0000_0400;

    logic clk = 1'b0;
    logic reset_s;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    instr_fetch_stage_if #(.LEN_WORD(32)) bus ();

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
    logic [31:0] flush_count;
`endif

    instr_fetch_stage #(
        .LEN_WORD (32),
        .RESET_PC (0),
        .SIZE_MEM (256)
    ) dut (
        .i_clk   (clk),
        .i_reset (reset_s),
        .bus     (bus)
`ifdef FETCH_PERF_CNT_EN
       ,.o_fetch_count (fetch_count),
        .o_stall_count (stall_count),
        .o_flush_count (flush_count)
`endif
    );

    // Instruction ROM contents: a distinct word per in-range address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        if (a < LIMIT) return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
        else           return 32'hDEAD_BEEF;
    endfunction

    assign bus.imem_data = rom_word(bus.imem_addr);

    // Behavioural model: HALT is exactly "pc outside the ROM range".
    logic [31:0]     m_pc, m_instr, m_p4;
    logic            m_v;
    longint unsigned m_fc, m_sc, m_flc;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step(input logic rst, input logic rv, input logic [31:0] rpc, input logic st);
        reset_s            = rst;
        bus.redirect_valid = rv;
        bus.redirect_pc    = rpc;
        bus.stall          = st;
        @(posedge clk);
        if (rst) begin
            m_pc = 32'h0; m_instr = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
            m_fc = 0; m_sc = 0; m_flc = 0;
        end else if (rv) begin
            m_pc = {rpc[31:2], 2'b00}; m_instr = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
            m_flc++;
        end else if (m_pc >= LIMIT) begin
            m_instr = 32'h0; m_p4 = 32'h0; m_v = 1'b0;
        end else if (st) begin
            m_sc++;
        end else begin
            m_instr = rom_word(m_pc); m_p4 = m_pc + 32'd4; m_v = 1'b1;
            m_pc = m_pc + 32'd4;
            m_fc++;
        end
        #1;
        chk("model_pc",    bus.imem_addr,            m_pc);
        chk("model_instr", bus.ifid_instr,           m_instr);
        chk("model_p4",    bus.ifid_pc_plus4,        m_p4);
        chk("model_valid", {31'b0, bus.ifid_valid},  {31'b0, m_v});
        chk("model_halt",  {31'b0, bus.halted},      {31'b0, (m_pc >= LIMIT)});
`ifdef FETCH_PERF_CNT_EN
        chk("model_fcnt",  fetch_count, m_fc[31:0]);
        chk("model_scnt",  stall_count, m_sc[31:0]);
        chk("model_flcnt", flush_count, m_flc[31:0]);
`endif
    endtask

    typedef struct {
        logic        rst;
        logic        rv;
        logic [31:0] rpc;
        logic        st;
        logic [31:0] e_pc;
        logic [31:0] e_p4;
        logic [31:0] e_instr;
        logic        e_v;
        logic        e_h;
    } vec_t;

    vec_t tbl [10];

    initial begin
        tbl[0] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h00, 32'h0,            1'b0, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 32'h0,  1'b0, 32'h00, 32'h00, 32'h0,            1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h04, 32'h04, rom_word(32'h00), 1'b1, 1'b0};
        tbl[3] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h08, 32'h08, rom_word(32'h04), 1'b1, 1'b0};
        tbl[4] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h08, rom_word(32'h04), 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h08, rom_word(32'h04), 1'b1, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 32'h0,  1'b1, 32'h08, 32'h08, rom_word(32'h04), 1'b1, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h0C, 32'h0C, rom_word(32'h08), 1'b1, 1'b0};
        tbl[8] = '{1'b0, 1'b1, 32'h1E, 1'b1, 32'h1C, 32'h00, 32'h0,            1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 32'h0,  1'b0, 32'h20, 32'h20, rom_word(32'h1C), 1'b1, 1'b0};

        reset_s = 1'b1; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.stall = 1'b0;
        @(negedge clk);

        // Directed table: reset, sequential fetch, stall hold, redirect under stall.
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rst, tbl[i].rv, tbl[i].rpc, tbl[i].st);
            chk($sformatf("tbl%0d_pc", i),    bus.imem_addr,           tbl[i].e_pc);
            chk($sformatf("tbl%0d_p4", i),    bus.ifid_pc_plus4,       tbl[i].e_p4);
            chk($sformatf("tbl%0d_instr", i), bus.ifid_instr,          tbl[i].e_instr);
            chk($sformatf("tbl%0d_valid", i), {31'b0, bus.ifid_valid}, {31'b0, tbl[i].e_v});
            chk($sformatf("tbl%0d_halt", i),  {31'b0, bus.halted},     {31'b0, tbl[i].e_h});
        end

        // Run off the end of the ROM: last word captured on the halting edge.
        step(1'b0, 1'b1, 32'h3F0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("end_instr", bus.ifid_instr, rom_word(32'h3FC));
        chk("end_pc",    bus.imem_addr,  32'h400);
        chk("end_halt",  {31'b0, bus.halted}, 32'h1);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("halt_valid", {31'b0, bus.ifid_valid}, 32'h0);
        chk("halt_pc",    bus.imem_addr, 32'h400);
        step(1'b0, 1'b1, 32'h0, 1'b0);
        chk("resume_halt", {31'b0, bus.halted}, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        chk("resume_p4", bus.ifid_pc_plus4, 32'h4);
        step(1'b0, 1'b1, 32'h400, 1'b0);
        chk("redir_oor_halt", {31'b0, bus.halted}, 32'h1);
        step(1'b0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        chk("redir_top_pc", bus.imem_addr, 32'hFFFF_FFFC);

        // Reset in the middle of a valid fetch.
        step(1'b0, 1'b1, 32'h1C, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("rst_pc",    bus.imem_addr, 32'h0);
        chk("rst_valid", {31'b0, bus.ifid_valid}, 32'h0);
        chk("rst_instr", bus.ifid_instr, 32'h0);

`ifdef FETCH_PERF_CNT_EN
        for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h40, 1'b0);
        chk("cnt_fetch", fetch_count, 32'd5);
        chk("cnt_stall", stall_count, 32'd2);
        chk("cnt_flush", flush_count, 32'd1);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        chk("cnt_clear", fetch_count | stall_count | flush_count, 32'd0);
`endif

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic        r_rst, r_rv, r_st;
            logic [31:0] r_pc;
            r_rst = ($urandom_range(63, 0) == 0);
            r_rv  = ($urandom_range(9, 0) == 0);
            r_st  = ($urandom_range(3, 0) == 0);
            case ($urandom_range(3, 0))
                0:       r_pc = 32'($urandom_range(1023, 0));
                1:       r_pc = 32'h3E0 + 32'($urandom_range(40, 0));
                2:       r_pc = $urandom;
                default: r_pc = 32'hFFFF_FFF0 + 32'($urandom_range(15, 0));
            endcase
            step(r_rst, r_rv, r_pc, r_st);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
